// File: rtl/booth_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_product_accumulator                                                |
// | Sums blocks of signed Booth products and emits one sum per block, with   |
// | optional saturation and a sticky overflow flag.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module booth_product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int BLOCK_LEN = 4,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*WIDTH-1:0]             in_product,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_sum,
  output logic [$clog2(BLOCK_LEN):0]     out_count,
  output logic                           out_overflow
);

  localparam int CW = $clog2(BLOCK_LEN) + 1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0]        out_count_q, out_count_d;
  logic                 out_overflow_q, out_overflow_d;

  logic [ACC_WIDTH:0]   ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_add;
  logic [CW-1:0]        cnt_inc;
  logic                 block_end;

  assign in_ready     = (state_q == ACCUM) & ~rst;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;

  // One guard bit: the top two bits of the widened sum disagree exactly on overflow.
  assign ext      = {{(ACC_WIDTH+1-2*WIDTH){in_product[2*WIDTH-1]}}, in_product};
  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + ext;
  assign add_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

  always_comb begin
    acc_add = sum_wide[ACC_WIDTH-1:0];
    if (SATURATE && add_ovf) begin
      acc_add = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  assign cnt_inc   = cnt_q + CW'(1);
  assign block_end = (cnt_inc == CW'(BLOCK_LEN)) | in_last;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
    case (state_q)
      ACCUM: begin
        if (in_valid && in_ready) begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (block_end) begin
            out_valid_d    = 1'b1;
            out_sum_d      = acc_add;
            out_count_d    = cnt_inc;
            out_overflow_d = ovf_q | add_ovf;
            state_d        = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_booth_product_accumulator                                             |
// | Directed bench: default config, 16-bit saturating and 16-bit wrapping.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_last   [3];
  logic        out_ready [3];
  logic [15:0] in_product[3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ovf   [3];
  logic [2:0]  out_count [3];
  logic [23:0] sum_a;
  logic [15:0] sum_b;
  logic [15:0] sum_c;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .BLOCK_LEN(4), .SATURATE(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_product(in_product[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(sum_a), .out_count(out_count[0]),
    .out_overflow(out_ovf[0])
  );

  booth_product_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .BLOCK_LEN(4), .SATURATE(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_product(in_product[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(sum_b), .out_count(out_count[1]),
    .out_overflow(out_ovf[1])
  );

  booth_product_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .BLOCK_LEN(4), .SATURATE(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_product(in_product[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_sum(sum_c), .out_count(out_count[2]),
    .out_overflow(out_ovf[2])
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint get_sum(input int k);
    case (k)
      0:       return longint'($signed(sum_a));
      1:       return longint'($signed(sum_b));
      default: return longint'($signed(sum_c));
    endcase
  endfunction

  // Presents one beat and returns 1 time unit after the accepting edge.
  task automatic send(input int k, input int p, input bit last);
    int n;
    in_valid[k]   = 1'b1;
    in_product[k] = p[15:0];
    in_last[k]    = last;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic result(input string tag, input int k, input longint s,
                        input int c, input bit o);
    check({tag, "_valid"}, out_valid[k], 1);
    check({tag, "_sum"},   get_sum(k),   s);
    check({tag, "_count"}, out_count[k], c);
    check({tag, "_ovf"},   out_ovf[k],   o);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k]   = 1'b0;
      in_last[k]    = 1'b0;
      out_ready[k]  = 1'b1;
      in_product[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready[0], 0);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_sum", get_sum(0), 0);
    check("rst_count", out_count[0], 0);
    check("rst_ovf", out_ovf[0], 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready[0], 1);

    // Full block, back-to-back.
    send(0, 9052, 0);
    send(0, 4, 0);
    send(0, 2401, 0);
    check("t1_no_early_valid", out_valid[0], 0);
    send(0, 3276, 0);
    result("t1", 0, 14733, 4, 0);
    check("t1_hold_in_ready", in_ready[0], 0);
    @(posedge clk); #1;
    check("t1_valid_dropped", out_valid[0], 0);

    // Early close with in_last.
    send(0, 45, 0);
    send(0, 120, 1);
    result("t2", 0, 165, 2, 0);
    check("t2_in_ready_hold", in_ready[0], 0);
    @(posedge clk); #1;
    check("t2_in_ready_back", in_ready[0], 1);
    check("t2_valid_dropped", out_valid[0], 0);

    // Backpressure while the next beat waits.
    out_ready[0] = 1'b0;
    send(0, 1, 0);
    send(0, 2, 0);
    send(0, 3, 0);
    send(0, 4, 0);
    result("t3", 0, 10, 4, 0);
    in_valid[0]   = 1'b1;
    in_product[0] = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t3_stall_in_ready", in_ready[0], 0);
      check("t3_stall_valid", out_valid[0], 1);
      check("t3_stall_sum", get_sum(0), 10);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("t3_after_hs_valid", out_valid[0], 0);
    check("t3_after_hs_in_ready", in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    send(0, 5, 1);
    result("t3_new_block", 0, 12, 2, 0);
    @(posedge clk); #1;

    // Reset mid-block discards partial sum.
    send(0, 100, 0);
    send(0, 200, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_in_ready", in_ready[0], 0);
    check("t5_rst_valid", out_valid[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_after_rst_valid", out_valid[0], 0);
    send(0, 1, 0);
    send(0, 2, 0);
    send(0, 3, 0);
    send(0, 4, 0);
    result("t5", 0, 10, 4, 0);
    @(posedge clk); #1;
    check("t5_single_result", out_valid[0], 0);

    // Cancelling products.
    send(0, -9052, 0);
    send(0, 9052, 0);
    send(0, -1, 0);
    send(0, 0, 0);
    result("t6", 0, -1, 4, 0);
    @(posedge clk); #1;

    // Saturation, 16-bit accumulator.
    for (int i = 0; i < 4; i++) send(1, 16129, 0);
    result("t4_sat_pos", 1, 32767, 4, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(1, -16256, 0);
    result("t4_sat_neg", 1, -32768, 4, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(1, 16129, 0);
    send(1, -16129, 0);
    result("t4_sticky", 1, 16638, 4, 1);
    @(posedge clk); #1;

    // Wrapping, 16-bit accumulator.
    for (int i = 0; i < 4; i++) send(2, 16129, 0);
    result("t4_wrap", 2, -1020, 4, 1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
